// File: rtl/demultiplexor_1in_2out_stream.sv
// ---------------------------------------------------------------------------
// demultiplexor_1in_2out_stream
//
// Steers a single valid/ready input stream of WIDTH-bit words to one of two
// buffered destinations (A or B), chosen per word by SelIn. Each destination
// has its own DEPTH-entry FIFO, so a stalled consumer never blocks words
// already queued for the other one. Only the FIFO selected by the word
// currently presented can stall the producer (head-of-line blocking).
//
// Parameters:
//   WIDTH    data word width in bits (default 16)
//   DEPTH    entries per output FIFO, power of two, >= 2 (default 2)
//
// Ports:
//   Clk              system clock, rising edge
//   Reset_n          asynchronous active-low reset
//   DatoIn/SelIn     input word and destination select (0 -> A, 1 -> B)
//   ValidIn/ReadyIn  input handshake; ReadyIn = selected FIFO not full
//   SalidaA/ValidA/ReadyA   destination A head word and handshake
//   SalidaB/ValidB/ReadyB   destination B head word and handshake
//   CountA/CountB    (DEMUX_COUNT_EN only) 16-bit wrapping counts of words
//                    accepted into FIFO A / FIFO B
//
// Build option:
//   DEMUX_COUNT_EN   when defined, adds the CountA/CountB outputs.
// ---------------------------------------------------------------------------

// Single-clock FIFO whose head entry is driven straight from the storage
// registers, so the output never has a combinational path from the write data.
module demux_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == FULL_CNT);
    assign pop     = valid_o && ready_i;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

module demultiplexor_1in_2out_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] DatoIn,
    input  logic             SelIn,
    input  logic             ValidIn,
    output logic             ReadyIn,
    output logic [WIDTH-1:0] SalidaA,
    output logic             ValidA,
    input  logic             ReadyA,
    output logic [WIDTH-1:0] SalidaB,
    output logic             ValidB,
    input  logic             ReadyB
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]      CountA,
    output logic [15:0]      CountB
`endif
);

    logic full_a;
    logic full_b;
    logic accept;
    logic push_a;
    logic push_b;

    // ReadyIn looks only at the selected FIFO's registered state, never at
    // the consumer readies: a full FIFO stalls even if it is popping.
    assign ReadyIn = SelIn ? !full_b : !full_a;
    assign accept  = ValidIn && ReadyIn;
    assign push_a  = accept && !SelIn;
    assign push_b  = accept &&  SelIn;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .push_i  (push_a),
        .data_i  (DatoIn),
        .ready_i (ReadyA),
        .data_o  (SalidaA),
        .valid_o (ValidA),
        .full_o  (full_a)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .push_i  (push_b),
        .data_i  (DatoIn),
        .ready_i (ReadyB),
        .data_o  (SalidaB),
        .valid_o (ValidB),
        .full_o  (full_b)
    );

`ifdef DEMUX_COUNT_EN
    logic [15:0] count_a_q;
    logic [15:0] count_b_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_a_q <= '0;
            count_b_q <= '0;
        end else begin
            if (push_a) begin
                count_a_q <= count_a_q + 16'd1;
            end
            if (push_b) begin
                count_b_q <= count_b_q + 16'd1;
            end
        end
    end

    assign CountA = count_a_q;
    assign CountB = count_b_q;
`endif

endmodule

// File: tb/tb_demultiplexor_1in_2out_stream.sv
module tb_demultiplexor_1in_2out_stream;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] DatoIn;
    logic        SelIn;
    logic        ValidIn;
    logic        ReadyIn;
    logic [15:0] SalidaA;
    logic        ValidA;
    logic        ReadyA;
    logic [15:0] SalidaB;
    logic        ValidB;
    logic        ReadyB;
`ifdef DEMUX_COUNT_EN
    logic [15:0] CountA;
    logic [15:0] CountB;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    always #5 Clk = ~Clk;

    demultiplexor_1in_2out_stream #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .DatoIn  (DatoIn),
        .SelIn   (SelIn),
        .ValidIn (ValidIn),
        .ReadyIn (ReadyIn),
        .SalidaA (SalidaA),
        .ValidA  (ValidA),
        .ReadyA  (ReadyA),
        .SalidaB (SalidaB),
        .ValidB  (ValidB),
        .ReadyB  (ReadyB)
`ifdef DEMUX_COUNT_EN
        ,
        .CountA  (CountA),
        .CountB  (CountB)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge whenever
    // ValidX && ReadyX is seen here, so compare the head against the queue.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (ValidA && ReadyA) begin
                if (exp_a.size() == 0) begin
                    chk("unexpected_A", {16'h0, SalidaA}, 32'hFFFF_FFFF);
                end else begin
                    chk("data_A", {16'h0, SalidaA}, {16'h0, exp_a.pop_front()});
                end
            end
            if (ValidB && ReadyB) begin
                if (exp_b.size() == 0) begin
                    chk("unexpected_B", {16'h0, SalidaB}, 32'hFFFF_FFFF);
                end else begin
                    chk("data_B", {16'h0, SalidaB}, {16'h0, exp_b.pop_front()});
                end
            end
        end
    end

    // Presents a word and holds it until accepted; returns 1 ns after the
    // accepting edge. The expected word is queued only once acceptance is known.
    task automatic push(input logic [15:0] d, input logic s);
        DatoIn  = d;
        SelIn   = s;
        ValidIn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (ReadyIn) begin
                if (s) exp_b.push_back(d);
                else   exp_a.push_back(d);
                @(posedge Clk);
                #1;
                ValidIn = 1'b0;
                return;
            end
        end
        chk("push_timeout", 32'h0, 32'h1);
        ValidIn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
        end
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        DatoIn  = '0;
        SelIn   = 1'b0;
        ValidIn = 1'b0;
        ReadyA  = 1'b0;
        ReadyB  = 1'b0;
        idle(3);
        Reset_n = 1'b1;
        #1;

        // Reset state
        chk("rst_validA",  {31'h0, ValidA}, 32'h0);
        chk("rst_validB",  {31'h0, ValidB}, 32'h0);
        chk("rst_salidaA", {16'h0, SalidaA}, 32'h0);
        chk("rst_salidaB", {16'h0, SalidaB}, 32'h0);
        chk("rst_readyin_A", {31'h0, ReadyIn}, 32'h1);
        SelIn = 1'b1;
        #1;
        chk("rst_readyin_B", {31'h0, ReadyIn}, 32'h1);
        idle(1);

        // Steering with one-cycle latency and no cross-leak
        ReadyA = 1'b1;
        ReadyB = 1'b1;
        push(16'h1234, 1'b0);
        chk("steer_validA",  {31'h0, ValidA}, 32'h1);
        chk("steer_salidaA", {16'h0, SalidaA}, 32'h1234);
        chk("steer_noleakB", {31'h0, ValidB}, 32'h0);
        push(16'hABCD, 1'b1);
        chk("steer_validB",  {31'h0, ValidB}, 32'h1);
        chk("steer_salidaB", {16'h0, SalidaB}, 32'hABCD);
        chk("steer_A_popped", {31'h0, ValidA}, 32'h0);
        idle(2);

        // Fill A, head-of-line blocking, B still reachable, ordered drain
        ReadyA = 1'b0;
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        SelIn = 1'b0;
        #1;
        chk("full_readyin_A", {31'h0, ReadyIn}, 32'h0);
        SelIn = 1'b1;
        #1;
        chk("full_readyin_B", {31'h0, ReadyIn}, 32'h1);
        push(16'h0003, 1'b1);
        chk("hold_validA",  {31'h0, ValidA}, 32'h1);
        chk("hold_salidaA", {16'h0, SalidaA}, 32'h0001);
        ReadyA = 1'b1;
        idle(3);
        chk("drain_validA", {31'h0, ValidA}, 32'h0);
        chk("drain_qA_empty", exp_a.size(), 32'h0);

        // Simultaneous push and pop at occupancy 1
        ReadyA = 1'b0;
        push(16'h00AA, 1'b0);
        chk("pp_pre_salidaA", {16'h0, SalidaA}, 32'h00AA);
        ReadyA = 1'b1;
        push(16'h00BB, 1'b0);
        chk("pp_validA",  {31'h0, ValidA}, 32'h1);
        chk("pp_salidaA", {16'h0, SalidaA}, 32'h00BB);
        idle(1);
        chk("pp_occupancy1", {31'h0, ValidA}, 32'h0);

        // Reset mid-stream with B full
        ReadyB = 1'b0;
        push(16'h0055, 1'b1);
        push(16'h0066, 1'b1);
        SelIn = 1'b1;
        #1;
        chk("midrst_fullB", {31'h0, ReadyIn}, 32'h0);
        #2;
        Reset_n = 1'b0;
        exp_b.delete();
        #1;
        chk("midrst_validB_async",  {31'h0, ValidB}, 32'h0);
        chk("midrst_salidaB_async", {16'h0, SalidaB}, 32'h0);
        chk("midrst_readyin_async", {31'h0, ReadyIn}, 32'h1);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle(1);
        chk("postrst_validB",  {31'h0, ValidB}, 32'h0);
        chk("postrst_readyin", {31'h0, ReadyIn}, 32'h1);

`ifdef DEMUX_COUNT_EN
        ReadyA = 1'b1;
        ReadyB = 1'b1;
        push(16'h0101, 1'b0);
        push(16'h0102, 1'b0);
        push(16'h0103, 1'b0);
        push(16'h0201, 1'b1);
        chk("countA_3", {16'h0, CountA}, 32'd3);
        chk("countB_1", {16'h0, CountB}, 32'd1);
        for (int i = 0; i < 65532; i++) begin
            push(16'(i), 1'b0);
        end
        chk("countA_ffff", {16'h0, CountA}, 32'hFFFF);
        push(16'h7777, 1'b0);
        chk("countA_wrap", {16'h0, CountA}, 32'h0);
        chk("countB_hold", {16'h0, CountB}, 32'd1);
`endif

        ReadyA = 1'b1;
        ReadyB = 1'b1;
        idle(4);
        chk("final_qA_empty", exp_a.size(), 32'h0);
        chk("final_qB_empty", exp_b.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demultiplexor_1in_2out_stream.md
Name: demultiplexor_1in_2out_stream

Overview:
Sequential counterpart to the 16-bit 2-to-1 datapath mux. It takes one 16-bit input stream, steers each word to destination A or B by a per-word select bit, and buffers each destination in its own small FIFO with valid/ready handshakes. It sits where a single datapath result must be delivered to one of two consumers, e.g. accumulator write-back versus memory/output port, without stalling the other consumer.

Parameters:
WIDTH, 16, data word width in bits.
DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
Clk  input  1  system clock, rising-edge active.
Reset_n  input  1  asynchronous active-low reset.
DatoIn  input  WIDTH  input data word.
SelIn  input  1  destination select: 0 -> A, 1 -> B; sampled with DatoIn.
ValidIn  input  1  DatoIn/SelIn valid.
ReadyIn  output  1  block can accept the word on the selected destination.
SalidaA  output  WIDTH  head word of FIFO A.
ValidA  output  1  SalidaA valid.
ReadyA  input  1  consumer A accepts SalidaA.
SalidaB  output  WIDTH  head word of FIFO B.
ValidB  output  1  SalidaB valid.
ReadyB  input  1  consumer B accepts SalidaB.

Behaviour:
- Single clock domain Clk; Reset_n is asynchronous assert, active-low; deassertion is synchronized externally.
- Reset: both FIFOs empty, pointers and counts 0, ValidA=ValidB=0, SalidaA=SalidaB=0. ReadyIn=1 while in reset and after release.
- ReadyIn = NOT full(FIFO selected by SelIn). Combinational from SelIn and registered FIFO state only; never depends on ReadyA/ReadyB, so there is no pass-through when the selected FIFO is full.
- Input transfer: ValidIn && ReadyIn at a rising edge. DatoIn is written to the tail of FIFO A (SelIn=0) or FIFO B (SelIn=1). The other FIFO is untouched.
- Output transfer: ValidX && ReadyX at a rising edge pops the head of FIFO X.
- Latency: a word accepted at edge k appears on SalidaX with ValidX=1 after edge k, if FIFO X was empty. No combinational path from DatoIn to SalidaX.
- ValidX = NOT empty(FIFO X). SalidaX is the registered head entry and holds stable while ValidX && !ReadyX.
- Each FIFO tracks occupancy 0..DEPTH with read/write pointers that wrap modulo DEPTH.
- Simultaneous push and pop on the same FIFO: occupancy unchanged, both pointers advance.
  - When occupancy was 1, the new word becomes the head on the next cycle.
  - When full, a push is impossible because ReadyIn=0.
- Word order is preserved within each destination. There is no ordering relation between A and B.
- Head-of-line blocking: if the selected FIFO is full, ReadyIn=0 even if the other FIFO has space. The upstream producer must hold DatoIn/SelIn stable until accepted.
- Once ValidX=1, it stays asserted until popped; it is never withdrawn.
- ReadyX while ValidX=0 is ignored.
- ValidIn=0 ignores DatoIn and SelIn.
- Reset mid-operation: contents are discarded immediately. Outputs return to reset values asynchronously, with no partial pops.

Optional Feature:
DEMUX_COUNT_EN.
- When defined, two extra outputs are present: CountA and CountB, each 16 bits. They are free-running counts of words accepted into FIFO A/B. They increment on each input transfer, wrap 0xFFFF -> 0x0000, and reset to 0.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: Reset_n=0 asynchronously mid-cycle -> ValidA=ValidB=0, SalidaA=SalidaB=0, ReadyIn=1 immediately, without waiting for a clock edge.
- Steering: push 0x1234 with SelIn=0, then 0xABCD with SelIn=1, ReadyA=ReadyB=1 -> SalidaA=0x1234 with ValidA one cycle after its push; SalidaB=0xABCD one cycle after its push; no cross-leak.
- Fill/backpressure: ReadyA=0, push 0x0001 and 0x0002 to A -> ReadyIn=0 while SelIn=0; switching to SelIn=1 gives ReadyIn=1 and 0x0003 is delivered to B. Then ReadyA=1 drains 0x0001 then 0x0002, in order.
- Simultaneous push/pop: FIFO A holds one word 0x00AA, ReadyA=1, push 0x00BB to A in the same cycle -> next cycle SalidaA=0x00BB, ValidA=1, occupancy 1.
- Reset mid-stream: FIFO B holds 2 words, assert Reset_n=0 -> ValidB drops immediately; after release ValidB=0 and ReadyIn=1.
- With DEMUX_COUNT_EN: accept 3 words to A and 1 to B -> CountA=3, CountB=1. Preload 0xFFFF, accept one more word to A -> CountA=0x0000.
